// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS decode stage: opcodes, ALU op classes,
// the control-bit bundle and the opcode decode table.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_RTYPE;
      end
      OP_LW: begin
        c.alusrc   = 1'b1;
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.aluop  = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_pipe_regfile.sv
// Architectural register file: two read ports, one write port, register 0
// hardwired to zero, and write-first bypass on both read ports.
module regfile_bypass
  import decode_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_hit;

  assign wr_hit = we_i && (waddr_i != '0) && (int'(waddr_i) < NUM_REGS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A write landing this edge is visible to a read in the same cycle.
  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0 || int'(addr) >= NUM_REGS) return '0;
    if (wr_hit && addr == waddr_i) return wdata_i;
    return regs_q[addr];
  endfunction

  assign rdata_a_o = read_port(raddr_a_i);
  assign rdata_b_o = read_port(raddr_b_i);

endmodule

// File: rtl/decode_pipe.sv
// MIPS instruction-decode stage with ID/EX pipeline register, valid/ready
// handshake, load-use bubble, branch flush and held-operand refresh.
module decode_pipe
  import decode_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int PC_W     = 32,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PC_W-1:0]   i_addr_NextPC,
  input  logic [31:0]       i_data_Instr,
  input  logic              i_flush,
  input  logic              i_con_RegWr,
  input  logic [REG_AW-1:0] i_addr_WrReg,
  input  logic [DATA_W-1:0] i_data_WrData,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_con_ex_regdst,
  output logic              o_con_ex_alusrc,
  output logic              o_con_mem_branch,
  output logic              o_con_mem_memread,
  output logic              o_con_mem_memwrite,
  output logic              o_con_wb_memtoreg,
  output logic              o_con_wb_regwrite,
  output logic [1:0]        o_con_ex_aluop,
  output logic              o_illegal,
  output logic [PC_W-1:0]   o_addr_NextPC,
  output logic [DATA_W-1:0] o_data_rs,
  output logic [DATA_W-1:0] o_data_rt,
  output logic [DATA_W-1:0] o_data_SignExt,
  output logic [REG_AW-1:0] o_addr_rs,
  output logic [REG_AW-1:0] o_addr_rt,
  output logic [REG_AW-1:0] o_addr_rd
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs_in, rt_in, rd_in;
  logic [DATA_W-1:0] rs_rd, rt_rd, sext_in;
  ctrl_t             ctrl_in;
  logic              uses_rt, adv, hazard, wb_hit;

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [PC_W-1:0]   npc_q, npc_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, sext_q, sext_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;

  assign opcode  = i_data_Instr[31:26];
  assign rs_in   = i_data_Instr[21 +: REG_AW];
  assign rt_in   = i_data_Instr[16 +: REG_AW];
  assign rd_in   = i_data_Instr[11 +: REG_AW];
  assign sext_in = {{(DATA_W-16){i_data_Instr[15]}}, i_data_Instr[15:0]};
  assign ctrl_in = decode_op(opcode);
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign wb_hit  = i_con_RegWr && (i_addr_WrReg != '0);

  regfile_bypass #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .we_i     (i_con_RegWr),
    .waddr_i  (i_addr_WrReg),
    .wdata_i  (i_data_WrData),
    .raddr_a_i(rs_in),
    .rdata_a_o(rs_rd),
    .raddr_b_i(rt_in),
    .rdata_b_o(rt_rd)
  );

  // A load in ID/EX whose destination feeds the incoming instruction forces a bubble.
  assign adv    = i_ready || !valid_q;
  assign hazard = i_valid && valid_q && ctrl_q.memread && (rt_addr_q != '0) &&
                  ((rt_addr_q == rs_in) || (uses_rt && (rt_addr_q == rt_in)));
  assign o_ready = i_rst_n && (i_flush || (adv && !hazard));

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    npc_d     = npc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    sext_d    = sext_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    if (i_flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!adv) begin
      // Keep a stalled instruction's operands current with retiring writes.
      if (valid_q && wb_hit && rs_addr_q != '0 && i_addr_WrReg == rs_addr_q) rs_data_d = i_data_WrData;
      if (valid_q && wb_hit && rt_addr_q != '0 && i_addr_WrReg == rt_addr_q) rt_data_d = i_data_WrData;
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d   = i_valid;
      ctrl_d    = i_valid ? ctrl_in : '0;
      npc_d     = i_addr_NextPC;
      rs_data_d = rs_rd;
      rt_data_d = rt_rd;
      sext_d    = sext_in;
      rs_addr_d = rs_in;
      rt_addr_d = rt_in;
      rd_addr_d = rd_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      npc_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      sext_q    <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      npc_q     <= npc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      sext_q    <= sext_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign o_valid            = valid_q;
  assign o_con_ex_regdst    = ctrl_q.regdst;
  assign o_con_ex_alusrc    = ctrl_q.alusrc;
  assign o_con_mem_branch   = ctrl_q.branch;
  assign o_con_mem_memread  = ctrl_q.memread;
  assign o_con_mem_memwrite = ctrl_q.memwrite;
  assign o_con_wb_memtoreg  = ctrl_q.memtoreg;
  assign o_con_wb_regwrite  = ctrl_q.regwrite;
  assign o_con_ex_aluop     = ctrl_q.aluop;
  assign o_illegal          = ctrl_q.illegal;
  assign o_addr_NextPC      = npc_q;
  assign o_data_rs          = rs_data_q;
  assign o_data_rt          = rt_data_q;
  assign o_data_SignExt     = sext_q;
  assign o_addr_rs          = rs_addr_q;
  assign o_addr_rt          = rt_addr_q;
  assign o_addr_rd          = rd_addr_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed scoreboard bench for decode_pipe: expected ID/EX contents are
// queued when an instruction is presented and compared one cycle later.
module tb_decode_pipe;

  typedef struct {
    logic        valid;
    logic [9:0]  ctrl;
    logic        full;
    logic [31:0] npc, rsData, rtData, sext;
    logic [4:0]  rsA, rtA, rdA;
  } expT;

  logic        clk = 1'b0;
  logic        rstN;
  logic        validIn, readyOut, flushIn, wbEn, validOut, readyIn;
  logic [31:0] npcIn, instrIn, wbData;
  logic [4:0]  wbAddr;
  logic        regDst, aluSrc, branch, memRead, memWrite, memToReg, regWrite, illegal;
  logic [1:0]  aluOp;
  logic [31:0] npcOut, rsData, rtData, signExt;
  logic [4:0]  rsAddr, rtAddr, rdAddr;

  logic [31:0] modelRegs [32];
  expT         sbQ [$];
  expT         lastExp;
  string       stepName;
  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;

  always #5 clk = ~clk;

  decode_pipe dut (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(validIn), .o_ready(readyOut),
    .i_addr_NextPC(npcIn), .i_data_Instr(instrIn), .i_flush(flushIn),
    .i_con_RegWr(wbEn), .i_addr_WrReg(wbAddr), .i_data_WrData(wbData),
    .o_valid(validOut), .i_ready(readyIn),
    .o_con_ex_regdst(regDst), .o_con_ex_alusrc(aluSrc), .o_con_mem_branch(branch),
    .o_con_mem_memread(memRead), .o_con_mem_memwrite(memWrite),
    .o_con_wb_memtoreg(memToReg), .o_con_wb_regwrite(regWrite),
    .o_con_ex_aluop(aluOp), .o_illegal(illegal), .o_addr_NextPC(npcOut),
    .o_data_rs(rsData), .o_data_rt(rtData), .o_data_SignExt(signExt),
    .o_addr_rs(rsAddr), .o_addr_rt(rtAddr), .o_addr_rd(rdAddr)
  );

  // {regdst,alusrc,branch,memread,memwrite,memtoreg,regwrite,aluop[1:0],illegal}
  function automatic logic [9:0] expCtrl(input logic [5:0] op);
    case (op)
      6'b000000: return 10'b1000001_10_0;
      6'b100011: return 10'b0101011_00_0;
      6'b101011: return 10'b0100100_00_0;
      6'b000100: return 10'b0010000_01_0;
      6'b001000: return 10'b0100001_00_0;
      default:   return 10'b0000000_00_1;
    endcase
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] readModel(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wbEn && wbAddr == a) return wbData;
    return modelRegs[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s/%s: observed 0x%0h expected 0x%0h", stepName, tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    validIn = v;
    instrIn = instr;
    npcIn   = npcIn + 32'd4;
    wbEn    = we;
    wbAddr  = wa;
    wbData  = wd;
    #1;
  endtask

  task automatic pushLoad();
    expT e;
    e.valid  = validIn;
    e.ctrl   = validIn ? expCtrl(instrIn[31:26]) : 10'd0;
    e.full   = 1'b1;
    e.npc    = npcIn;
    e.rsA    = instrIn[25:21];
    e.rtA    = instrIn[20:16];
    e.rdA    = instrIn[15:11];
    e.rsData = readModel(e.rsA);
    e.rtData = readModel(e.rtA);
    e.sext   = {{16{instrIn[15]}}, instrIn[15:0]};
    lastExp  = e;
    sbQ.push_back(e);
  endtask

  task automatic pushBubble();
    expT e;
    e = '{valid: 1'b0, ctrl: 10'd0, full: 1'b0, npc: 32'd0, rsData: 32'd0,
          rtData: 32'd0, sext: 32'd0, rsA: 5'd0, rtA: 5'd0, rdA: 5'd0};
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstN && wbEn && wbAddr != 5'd0) modelRegs[wbAddr] = wbData;
    #1;
  endtask

  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL %s/scoreboard: observed empty queue expected an entry", stepName);
      return;
    end
    e = sbQ.pop_front();
    check("valid", {31'd0, validOut}, {31'd0, e.valid});
    check("ctrl", {22'd0, regDst, aluSrc, branch, memRead, memWrite, memToReg, regWrite,
                   aluOp, illegal}, {22'd0, e.ctrl});
    if (e.full) begin
      check("npc", npcOut, e.npc);
      check("rsData", rsData, e.rsData);
      check("rtData", rtData, e.rtData);
      check("sext", signExt, e.sext);
      check("addr", {17'd0, rsAddr, rtAddr, rdAddr}, {17'd0, e.rsA, e.rtA, e.rdA});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    rstN = 1'b0; validIn = 1'b0; instrIn = 32'd0; npcIn = 32'h100; flushIn = 1'b0;
    wbEn = 1'b0; wbAddr = 5'd0; wbData = 32'd0; readyIn = 1'b1;

    stepName = "reset";
    #12;
    check("ready", {31'd0, readyOut}, 32'd0);
    check("valid", {31'd0, validOut}, 32'd0);
    check("illegal", {31'd0, illegal}, 32'd0);
    check("sext", signExt, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    stepName = "bypass";
    applyStimulus(1'b1, rtype(5'd5, 5'd5, 5'd1), 1'b1, 5'd5, 32'h1234_5678);
    check("ready", {31'd0, readyOut}, 32'd1);
    pushLoad(); tick(); checkOutput();

    stepName = "loadUse";
    applyStimulus(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd0), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, rtype(5'd2, 5'd4, 5'd3), 1'b0, 5'd0, 32'd0);
    check("stallReady", {31'd0, readyOut}, 32'd0);
    pushBubble(); tick(); checkOutput();
    check("afterBubbleReady", {31'd0, readyOut}, 32'd1);
    pushLoad(); tick(); checkOutput();

    stepName = "noStall";
    applyStimulus(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd8), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, itype(6'b001000, 5'd0, 5'd2, 16'd3), 1'b0, 5'd0, 32'd0);
    check("ready", {31'd0, readyOut}, 32'd1);
    pushLoad(); tick(); checkOutput();

    stepName = "stallRefresh";
    applyStimulus(1'b1, rtype(5'd7, 5'd8, 5'd1), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    readyIn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, itype(6'b001000, 5'd0, 5'd9, 16'd5), k == 0, 5'd7, 32'hAA);
      check("holdReady", {31'd0, readyOut}, 32'd0);
      lastExp.rsData = 32'hAA;
      sbQ.push_back(lastExp);
      tick(); checkOutput();
    end

    stepName = "flush";
    readyIn = 1'b1;
    applyStimulus(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd0), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    readyIn = 1'b0;
    applyStimulus(1'b1, rtype(5'd2, 5'd4, 5'd3), 1'b0, 5'd0, 32'd0);
    flushIn = 1'b1;
    #1;
    check("flushReady", {31'd0, readyOut}, 32'd1);
    pushBubble(); tick(); checkOutput();
    check("flushCycleReady", {31'd0, readyOut}, 32'd1);
    @(negedge clk);
    flushIn = 1'b0;
    readyIn = 1'b1;
    #1;
    check("postFlushReady", {31'd0, readyOut}, 32'd1);

    stepName = "immIllegal";
    applyStimulus(1'b1, itype(6'b001000, 5'd0, 5'd4, 16'h8000), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, {6'b111111, 26'h0123456}, 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, itype(6'b101011, 5'd7, 5'd6, 16'd4), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, itype(6'b000100, 5'd5, 5'd7, 16'hFFFE), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, rtype(5'd0, 5'd0, 5'd9), 1'b1, 5'd0, 32'h0000_FFFF);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, rtype(5'd0, 5'd0, 5'd9), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b0, rtype(5'd5, 5'd7, 5'd9), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();

    stepName = "midReset";
    applyStimulus(1'b1, rtype(5'd5, 5'd5, 5'd1), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    @(negedge clk);
    readyIn = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    check("valid", {31'd0, validOut}, 32'd0);
    check("rsData", rsData, 32'd0);
    check("rdAddr", {27'd0, rdAddr}, 32'd0);
    check("regDst", {31'd0, regDst}, 32'd0);
    check("aluOp", {30'd0, aluOp}, 32'd0);
    check("ready", {31'd0, readyOut}, 32'd0);
    sbQ.delete();
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    @(negedge clk);
    rstN = 1'b1;
    readyIn = 1'b1;

    stepName = "resume";
    applyStimulus(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd0), 1'b0, 5'd0, 32'd0);
    pushLoad(); tick(); checkOutput();
    applyStimulus(1'b1, rtype(5'd2, 5'd5, 5'd3), 1'b0, 5'd0, 32'd0);
    check("stallReady", {31'd0, readyOut}, 32'd0);
    pushBubble(); tick(); checkOutput();
    pushLoad(); tick(); checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
